// File: rtl/mitec2_dram_seq.sv
// Clocked DRAM strobe sequencer for the mitec2 cartridge. It turns Z80 bus strobes into
// per-bank /RAS, /MUX and /CAS timing, plus RAS-only refresh and a debounced /NMI.
module mitec2_dram_seq #(
  parameter int NUM_BANKS   = 2,
  parameter int BANK_BITS   = 1,
  parameter int SYNC_STAGES = 2,
  parameter int T_RAS_MUX   = 2,
  parameter int T_MUX_CAS   = 2,
  parameter int T_PRECHARGE = 2,
  parameter int DEBOUNCE    = 16
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 MREQ,
  input  logic                 RD,
  input  logic                 WR,
  input  logic                 RFSH,
  input  logic                 CSSRAM,
  input  logic [BANK_BITS-1:0] A_BANK,
  input  logic                 A7,
  input  logic                 NMIN,
  output logic [NUM_BANKS-1:0] RAS,
  output logic [NUM_BANKS-1:0] CAS,
  output logic                 MUX,
  output logic                 RAMA7,
  output logic                 NMI,
  output logic                 BUSY
);
  localparam int IW = BANK_BITS + 7;
  localparam int CW = $clog2(DEBOUNCE) + 1;
  localparam int TW = 8;

  typedef enum logic [2:0] {IDLE, ROW, COL, ACTIVE, REFRESH, PRE} state_t;

  logic [IW-1:0]        sync_q [SYNC_STAGES];
  logic                 mreq_s, rd_s, wr_s, rfsh_s, cs_s, a7_s, nmin_s, nmin_pre;
  logic [BANK_BITS-1:0] bank_s;

  // Every async input shares one synchroniser chain; reset parks it at "inactive".
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '1;
    end else begin
      sync_q[0] <= {MREQ, RD, WR, RFSH, CSSRAM, A7, NMIN, A_BANK};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign {mreq_s, rd_s, wr_s, rfsh_s, cs_s, a7_s, nmin_s, bank_s} = sync_q[SYNC_STAGES-1];
  assign nmin_pre = sync_q[SYNC_STAGES-2][BANK_BITS];

  state_t               state, state_n;
  logic [TW-1:0]        cnt, cnt_n;
  logic [BANK_BITS-1:0] bank, bank_n;
  logic                 rama7_lat, rama7_lat_n;
  logic                 access_req, refresh_req;
  logic [NUM_BANKS-1:0] ras_n, cas_n;
  logic                 mux_n, rama7_n;

  assign access_req  = !mreq_s && rfsh_s && !cs_s && (rd_s != wr_s);
  assign refresh_req = !mreq_s && !rfsh_s;

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    bank_n      = bank;
    rama7_lat_n = rama7_lat;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (access_req) begin
          state_n     = ROW;
          bank_n      = bank_s;
          rama7_lat_n = a7_s & rfsh_s;
        end else if (refresh_req) begin
          state_n = REFRESH;
        end
      end
      ROW: begin
        if (mreq_s) begin
          state_n = PRE;
          cnt_n   = '0;
        end else if (cnt == TW'(T_RAS_MUX - 1)) begin
          state_n = COL;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + TW'(1);
        end
      end
      COL: begin
        // An abort here must win over the step to ACTIVE so CAS never pulses.
        if (mreq_s) begin
          state_n = PRE;
          cnt_n   = '0;
        end else if (cnt == TW'(T_MUX_CAS - 1)) begin
          state_n = ACTIVE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + TW'(1);
        end
      end
      ACTIVE: begin
        if (mreq_s) begin
          state_n = PRE;
          cnt_n   = '0;
        end
      end
      REFRESH: begin
        if (mreq_s || rfsh_s) begin
          state_n = PRE;
          cnt_n   = '0;
        end
      end
      PRE: begin
        if (cnt == TW'(T_PRECHARGE - 1)) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + TW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Strobes are decoded from the next state so they register on the same edge as the transition.
  always_comb begin
    ras_n   = '1;
    cas_n   = '1;
    mux_n   = 1'b1;
    rama7_n = 1'b0;
    case (state_n)
      ROW: ras_n[bank_n] = 1'b0;
      COL: begin
        ras_n[bank_n] = 1'b0;
        mux_n         = 1'b0;
        rama7_n       = rama7_lat_n;
      end
      ACTIVE: begin
        ras_n[bank_n] = 1'b0;
        cas_n[bank_n] = 1'b0;
        mux_n         = 1'b0;
        rama7_n       = rama7_lat_n;
      end
      REFRESH: ras_n = '0;
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= IDLE;
      cnt       <= '0;
      bank      <= '0;
      rama7_lat <= 1'b0;
      RAS       <= '1;
      CAS       <= '1;
      MUX       <= 1'b1;
      RAMA7     <= 1'b0;
      BUSY      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bank      <= bank_n;
      rama7_lat <= rama7_lat_n;
      RAS       <= ras_n;
      CAS       <= cas_n;
      MUX       <= mux_n;
      RAMA7     <= rama7_n;
      BUSY      <= (state_n != IDLE);
    end
  end

  logic [CW-1:0] db_cnt, db_cnt_n;

  // Change detection looks one stage ahead so the stability count starts as the level emerges.
  always_comb begin
    if (nmin_pre != nmin_s)              db_cnt_n = '0;
    else if (db_cnt == CW'(DEBOUNCE))    db_cnt_n = db_cnt;
    else                                 db_cnt_n = db_cnt + CW'(1);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      db_cnt <= '0;
      NMI    <= 1'b1;
    end else begin
      db_cnt <= db_cnt_n;
      if (db_cnt_n == CW'(DEBOUNCE)) NMI <= nmin_s;
    end
  end
endmodule

// File: tb/tb_mitec2_dram_seq.sv
// Bench for mitec2_dram_seq: a 2-bank and a 4-bank instance share the bus strobes and are
// checked edge by edge against timelines derived from the documented latencies.
module tb_mitec2_dram_seq;
  localparam int S  = 2;
  localparam int T1 = 2;
  localparam int T2 = 2;
  localparam int TP = 2;

  typedef struct packed {
    logic [3:0] r4;
    logic [3:0] c4;
    logic [1:0] r2;
    logic [1:0] c2;
    logic       mx;
    logic       ra;
    logic       bz;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mreq = 1'b1, rd = 1'b1, wr = 1'b1, rfsh = 1'b1, cssram = 1'b1;
  logic       a7 = 1'b0, nmin = 1'b1;
  logic       a_bank2 = 1'b0;
  logic [1:0] a_bank4 = 2'b00;
  logic [1:0] ras2, cas2;
  logic [3:0] ras4, cas4;
  logic       mux2, rama72, nmi2, busy2;
  logic       mux4, rama74, nmi4, busy4;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  mitec2_dram_seq dut2 (
    .CLK(clk), .RST_N(rst_n), .MREQ(mreq), .RD(rd), .WR(wr), .RFSH(rfsh), .CSSRAM(cssram),
    .A_BANK(a_bank2), .A7(a7), .NMIN(nmin),
    .RAS(ras2), .CAS(cas2), .MUX(mux2), .RAMA7(rama72), .NMI(nmi2), .BUSY(busy2)
  );

  mitec2_dram_seq #(.NUM_BANKS(4), .BANK_BITS(2)) dut4 (
    .CLK(clk), .RST_N(rst_n), .MREQ(mreq), .RD(rd), .WR(wr), .RFSH(rfsh), .CSSRAM(cssram),
    .A_BANK(a_bank4), .A7(a7), .NMIN(nmin),
    .RAS(ras4), .CAS(cas4), .MUX(mux4), .RAMA7(rama74), .NMI(nmi4), .BUSY(busy4)
  );

  function automatic exp_t idle_exp();
    exp_t x;
    x.r4 = '1; x.c4 = '1; x.r2 = '1; x.c2 = '1;
    x.mx = 1'b1; x.ra = 1'b0; x.bz = 1'b0;
    return x;
  endfunction

  // One access whose RAS falls at edge st and whose strobes release at edge en.
  function automatic exp_t add_win(exp_t xi, int e, int st, int en, int bank, int a7v);
    exp_t x;
    x = xi;
    if (e >= st && e < en) begin
      x.r4[bank] = 1'b0;
      x.r2[bank % 2] = 1'b0;
    end
    if (e >= st + T1 && e < en) begin
      x.mx = 1'b0;
      x.ra = (a7v != 0);
    end
    if (e >= st + T1 + T2 && e < en) begin
      x.c4[bank] = 1'b0;
      x.c2[bank % 2] = 1'b0;
    end
    if (e >= st && e < en + TP) x.bz = 1'b1;
    return x;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; mreq = 1'b0; rd = 1'b0; cssram = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if ({ras2, cas2, mux2, rama72, nmi2, busy2} !== 8'b11_11_1_0_1_0) begin
        errors++;
        $display("FAIL reset dut2 edge %0d got %b exp %b", e,
                 {ras2, cas2, mux2, rama72, nmi2, busy2}, 8'b11_11_1_0_1_0);
      end
      checks++;
      if ({ras4, cas4, mux4, rama74, nmi4, busy4} !== 12'b1111_1111_1_0_1_0) begin
        errors++;
        $display("FAIL reset dut4 edge %0d got %b exp %b", e,
                 {ras4, cas4, mux4, rama74, nmi4, busy4}, 12'b1111_1111_1_0_1_0);
      end
    end
    mreq = 1'b1; rd = 1'b1; cssram = 1'b1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
  endtask

  // mode 0: single access; mode 1: MREQ high one cycle then a second access;
  // mode 2: a one-cycle MREQ pulse that lands in precharge and must be dropped.
  task automatic run_seq(input string name, input int bank, input int a7v, input int is_wr,
                         input int l1, input int mode, input bit chg);
    int   st1, en1, st2, en2, last, l2, nb, k;
    exp_t x;
    logic [6:0]  e2;
    logic [10:0] e4;
    l2  = 6;
    nb  = chg ? (bank ^ 3) : bank;
    st1 = 1 + S;
    en1 = l1 + 1 + S;
    st2 = 0;
    en2 = 0;
    if (mode == 1) begin
      st2 = (l1 + 2 + S > en1 + TP + 1) ? l1 + 2 + S : en1 + TP + 1;
      en2 = l1 + 2 + l2 + S;
    end
    last = ((mode == 1) ? en2 : en1) + TP + 4;
    a_bank4 = 2'(bank); a_bank2 = a_bank4[0]; a7 = (a7v != 0);
    rd = (is_wr != 0); wr = (is_wr == 0); cssram = 1'b0; rfsh = 1'b1; mreq = 1'b0;
    for (int e = 1; e <= last; e++) begin
      @(posedge clk); @(negedge clk);
      x = add_win(idle_exp(), e, st1, en1, bank, a7v);
      if (mode == 1) x = add_win(x, e, st2, en2, nb, a7v);
      e2 = {x.r2, x.c2, x.mx, x.ra, x.bz};
      e4 = {x.r4, x.c4, x.mx, x.ra, x.bz};
      checks++;
      if ({ras2, cas2, mux2, rama72, busy2} !== e2) begin
        errors++;
        $display("FAIL %s dut2 edge %0d got %b exp %b", name, e,
                 {ras2, cas2, mux2, rama72, busy2}, e2);
      end
      checks++;
      if ({ras4, cas4, mux4, rama74, busy4} !== e4) begin
        errors++;
        $display("FAIL %s dut4 edge %0d got %b exp %b", name, e,
                 {ras4, cas4, mux4, rama74, busy4}, e4);
      end
      if (chg && e == 4) begin
        a_bank4 = 2'(nb);
        a_bank2 = a_bank4[0];
      end
      k = e + 1;
      if (k <= l1)                       mreq = 1'b0;
      else if (k == l1 + 1)              mreq = 1'b1;
      else if (mode == 1 && k <= l1 + 1 + l2) mreq = 1'b0;
      else if (mode == 2 && k == l1 + 2) mreq = 1'b0;
      else                               mreq = 1'b1;
    end
    mreq = 1'b1; rd = 1'b1; wr = 1'b1; cssram = 1'b1;
  endtask

  task automatic test_refresh(input int l, input int how);
    exp_t x;
    logic [6:0]  e2;
    logic [10:0] e4;
    rfsh = 1'b0; mreq = 1'b0; rd = 1'b1; wr = 1'b1; a7 = 1'b1;
    cssram = 1'($urandom_range(0, 1));
    for (int e = 1; e <= l + S + TP + 7; e++) begin
      @(posedge clk); @(negedge clk);
      x = idle_exp();
      if (e >= 1 + S && e < l + 1 + S) begin
        x.r4 = '0;
        x.r2 = '0;
      end
      x.bz = (e >= 1 + S && e < l + 1 + S + TP);
      e2 = {x.r2, x.c2, x.mx, x.ra, x.bz};
      e4 = {x.r4, x.c4, x.mx, x.ra, x.bz};
      checks++;
      if ({ras2, cas2, mux2, rama72, busy2} !== e2) begin
        errors++;
        $display("FAIL refresh dut2 edge %0d got %b exp %b", e, {ras2, cas2, mux2, rama72, busy2}, e2);
      end
      checks++;
      if ({ras4, cas4, mux4, rama74, busy4} !== e4) begin
        errors++;
        $display("FAIL refresh dut4 edge %0d got %b exp %b", e, {ras4, cas4, mux4, rama74, busy4}, e4);
      end
      if (e == l) begin
        rfsh = 1'b1;
        if (how == 0) mreq = 1'b1;
      end
      if (e == l + 3) mreq = 1'b1;
    end
    mreq = 1'b1; rfsh = 1'b1; cssram = 1'b1; a7 = 1'b0;
  endtask

  // Requests that fail the access qualification must leave every strobe idle.
  task automatic test_ignore();
    mreq = 1'b0; rd = 1'b0; wr = 1'b1; cssram = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if ({ras2, cas2, mux2, rama72, busy2} !== 7'b11_11_1_0_0 ||
          {ras4, cas4, mux4, rama74, busy4} !== 11'b1111_1111_1_0_0) begin
        errors++;
        $display("FAIL ignore edge %0d got %b %b exp idle", e,
                 {ras2, cas2, mux2, rama72, busy2}, {ras4, cas4, mux4, rama74, busy4});
      end
      if (e == 8) begin
        cssram = 1'b0;
        wr = 1'b0;
      end
    end
    mreq = 1'b1; rd = 1'b1; wr = 1'b1; cssram = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    a_bank4 = 2'b01; a_bank2 = 1'b1; a7 = 1'b0;
    rd = 1'b0; wr = 1'b1; cssram = 1'b0; rfsh = 1'b1; mreq = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    checks++;
    if (cas2 !== 2'b01 || busy2 !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_active got cas %b busy %b exp cas 01 busy 1", cas2, busy2);
    end
    rst_n = 1'b0; mreq = 1'b1; rd = 1'b1; cssram = 1'b1;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int e = 0; e <= 6; e++) begin
      checks++;
      if ({ras2, cas2, mux2, rama72, busy2} !== 7'b11_11_1_0_0 ||
          {ras4, cas4, mux4, rama74, busy4} !== 11'b1111_1111_1_0_0) begin
        errors++;
        $display("FAIL reset_mid edge %0d got %b %b exp idle", e,
                 {ras2, cas2, mux2, rama72, busy2}, {ras4, cas4, mux4, rama74, busy4});
      end
      @(posedge clk); @(negedge clk);
    end
  endtask

  // NMI follows NMIN once the raw level has held for DEBOUNCE+1 samples, seen SYNC_STAGES late.
  task automatic test_debounce();
    logic h[$];
    logic exp_nmi, same;
    int   lv[$];
    int   ln[$];
    h = {};
    for (int i = 0; i < 17; i++) h.push_back(1'b1);
    exp_nmi = 1'b1;
    lv = {0, 1, 0, 1, 0};
    ln = {10, 3, 30, 5, 30};
    for (int i = 0; i < 6; i++) begin
      lv.push_back(i % 2 == 0 ? 1 : 0);
      ln.push_back(int'($urandom_range(1, 22)));
    end
    lv.push_back(1);
    ln.push_back(30);
    for (int sg = 0; sg < lv.size(); sg++) begin
      for (int c = 1; c <= ln[sg]; c++) begin
        nmin = (lv[sg] != 0);
        @(posedge clk);
        same = 1'b1;
        for (int k = 1; k <= 17; k++)
          if (h[h.size() - k] !== h[h.size() - 1]) same = 1'b0;
        if (same) exp_nmi = h[h.size() - 2];
        h.push_back(nmin);
        if (h.size() > 40) void'(h.pop_front());
        @(negedge clk);
        checks++;
        if (nmi2 !== exp_nmi || nmi4 !== exp_nmi) begin
          errors++;
          $display("FAIL debounce seg %0d cycle %0d got %b %b exp %b", sg, c, nmi2, nmi4, exp_nmi);
        end
        if (sg == 2 && (c == 17 || c == 18)) begin
          checks++;
          if (nmi2 !== (c == 17)) begin
            errors++;
            $display("FAIL debounce_edge18 edge %0d got %b exp %b", c, nmi2, (c == 17));
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    run_seq("read_bank1", 1, 1, 0, 10, 0, 1'b0);
    test_refresh(6, 0);
    test_refresh(5, 1);
    run_seq("abort", 0, 1, 1, 4, 0, 1'b0);
    run_seq("bank4_write", 2, 0, 1, 10, 0, 1'b1);
    test_ignore();
    run_seq("back_to_back", 3, 1, 0, 8, 1, 1'b0);
    run_seq("pre_pulse", 1, 0, 1, 7, 2, 1'b0);
    for (int i = 0; i < 12; i++)
      run_seq("random", int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
              int'($urandom_range(0, 1)), int'($urandom_range(1, 12)),
              int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    test_reset_mid();
    test_debounce();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mitec2_dram_seq.md
# mitec2_dram_seq

Clocked, parametrised successor to the mitec2 combinational DRAM strobe decode. It turns Z80 bus strobes into properly sequenced /RAS, /MUX, /CAS per DRAM bank, plus RAS-only refresh and a debounced /NMI. Delays are counted in clock cycles, not gate delays. It sits between the Z80 bus and the cartridge DRAM banks and takes /CSSRAM from the address decode.

## Interface

Parameters:
- NUM_BANKS, 2: DRAM banks; power of two, 2..8.
- BANK_BITS, 1: log2(NUM_BANKS).
- SYNC_STAGES, 2: synchroniser flops on every async input, ≥2.
- T_RAS_MUX, 2: cycles from /RAS fall to /MUX fall, ≥1.
- T_MUX_CAS, 2: cycles from /MUX fall to /CAS fall, ≥1.
- T_PRECHARGE, 2: cycles all strobes held high after a cycle ends, ≥1.
- DEBOUNCE, 16: consecutive stable cycles needed before /NMI changes, ≥2.

Ports:
- CLK  in  1  system clock; only clock.
- RST_N  in  1  reset; synchronous, active-low.
- MREQ, RD, WR, RFSH  in  1 each  Z80 strobes, active-low, asynchronous.
- CSSRAM  in  1  active-low DRAM select from decode, asynchronous.
- A_BANK  in  BANK_BITS  bank-select address bits; for NUM_BANKS=2 this is A14.
- A7  in  1  CPU A7.
- NMIN  in  1  raw /NMI button, active-low, bouncy.
- RAS  out  NUM_BANKS  per-bank /RAS, active-low.
- CAS  out  NUM_BANKS  per-bank /CAS, active-low.
- MUX  out  1  row/column address mux, low = column.
- RAMA7  out  1  DRAM A7 replacement.
- NMI  out  1  debounced /NMI, active-low.
- BUSY  out  1  high when the FSM is not in IDLE.

## Operation

- All async inputs pass through SYNC_STAGES flops. A_BANK and A7 are sampled from the synchronised copy.
- Access request, evaluated only in IDLE: MREQ=0, RFSH=1, CSSRAM=0, and exactly one of RD, WR low.
- Refresh request, evaluated only in IDLE: MREQ=0 and RFSH=0. The two requests are mutually exclusive by RFSH.
- FSM states:
  - IDLE: all strobes high. An access request latches the bank and goes to ROW. A refresh request goes to REFRESH. Otherwise stay in IDLE.
  - ROW: RAS[bank]=0. After T_RAS_MUX cycles, go to COL.
  - COL: RAS[bank]=0, MUX=0. After T_MUX_CAS cycles, go to ACTIVE.
  - ACTIVE: RAS[bank]=0, MUX=0, CAS[bank]=0. Hold until synchronised MREQ=1, then go to PRE.
  - REFRESH: all RAS=0; CAS and MUX stay high. Hold until MREQ=1 or RFSH=1, then go to PRE.
  - PRE: all strobes high for T_PRECHARGE cycles, then go to IDLE.
- Abort: if MREQ returns high in ROW or COL, go to PRE on the next edge. CAS must never assert in that cycle.
- Requests arriving during PRE are not queued. They are taken in IDLE only if still present.
- Only the latched bank's RAS/CAS move during an access. A_BANK changes mid-cycle are ignored.
- RAMA7 is A7 AND RFSH, registered at entry to ROW. It is driven only while MUX=0 and forced to 0 whenever MUX=1.
- NMI debounce:
  - A counter of width clog2(DEBOUNCE)+1 clears whenever the synchronised NMIN differs from its previous sample.
  - Otherwise the counter increments, saturating at DEBOUNCE.
  - NMI takes the sampled level when the counter reaches DEBOUNCE.
- BUSY = (state ≠ IDLE).

## Timing

- All outputs are registered. No combinational path from input to output.
- Reset values: RAS all 1, CAS all 1, MUX 1, RAMA7 0, NMI 1, BUSY 0. The FSM and all counters are cleared.
- Reset asserted mid-cycle: on the next edge, all outputs take their reset values and the FSM goes to IDLE. The synchroniser contents are also cleared to 1 (inactive).
- Access latency from the MREQ edge:
  - RAS[bank] falls SYNC_STAGES+1 edges after the MREQ edge.
  - MUX falls T_RAS_MUX edges after RAS.
  - CAS falls T_MUX_CAS edges after MUX.
- Release: all strobes high SYNC_STAGES+1 edges after MREQ rises. The earliest next RAS fall is T_PRECHARGE+1 edges later.
- NMI changes exactly DEBOUNCE+SYNC_STAGES edges after NMIN last changed. Glitches shorter than DEBOUNCE cycles never reach NMI.

## Test plan

- Reset: hold RST_N=0 for 3 edges with MREQ=0, RD=0 → RAS=2'b11, CAS=2'b11, MUX=1, RAMA7=0, NMI=1, BUSY=0 throughout.
- Read, bank 1, defaults: MREQ=0, RD=0, A_BANK=1, A7=1 → RAS=2'b01 at edge 3; MUX=0 and RAMA7=1 at edge 5; CAS=2'b01 at edge 7. Then MREQ=1 → all high 3 edges later; BUSY falls 2 edges after that.
- Refresh: MREQ=0, RFSH=0 for 6 cycles → RAS=2'b00 from edge 3; CAS=2'b11 and MUX=1 throughout; RAMA7=0.
- Abort: MREQ low for 4 cycles with WR=0, A_BANK=0 → RAS[0] pulses low; CAS never asserts; PRE entered; BUSY clears.
- Debounce: NMIN=0 for 10 cycles, high for 3, then low steadily → NMI stays 1 during the bounce; falls exactly 18 edges after the final NMIN edge; a 5-cycle high glitch afterwards leaves NMI=0.
- NUM_BANKS=4, BANK_BITS=2, A_BANK=2'b10, write → only RAS[2] and CAS[2] assert; a mid-cycle A_BANK change to 2'b01 has no effect.
